precision_unpacker: RTL and testbench



---
 rtl/stripes_pkg.sv | 20 ++
 rtl/precision_expand.sv | 30 +++
 rtl/precision_unpacker.sv | 155 +++++++++++++++
 tb/tb_precision_unpacker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stripes_pkg.sv
// Shared definitions for the Stripes reduced-precision datapath:
// controller states, default widths and a ceiling-divide helper.
package stripes_pkg;

   localparam int unsigned N_DEF       = 16;
   localparam int unsigned BIT_IDX_DEF = 4;
   localparam int unsigned PREC_W_DEF  = 5;
   localparam int unsigned CNT_W_DEF   = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
      return (num + den - 32'd1) / den;
   endfunction

endpackage

// File: rtl/precision_expand.sv
// Sign-extends the low prec bits of a word to full width, then shifts left
// by offset to restore fractional alignment.
module precision_expand
   import stripes_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned BIT_IDX = BIT_IDX_DEF,
   parameter int unsigned PREC_W  = PREC_W_DEF
) (
   input  logic [N-1:0]       i_bits,
   input  logic [PREC_W-1:0]  i_prec,
   input  logic [BIT_IDX-1:0] i_offset,
   output logic [N-1:0]       o_data
);

   localparam logic [PREC_W-1:0] LP_N = PREC_W'(N);

   logic [PREC_W-1:0] w_gap;
   logic signed [N-1:0] w_aligned;
   logic signed [N-1:0] w_sext;

   // Park the value's sign bit at the MSB, then arithmetic-shift back down.
   always_comb begin
      w_gap     = ((i_prec == '0) || (i_prec > LP_N)) ? '0 : (LP_N - i_prec);
      w_aligned = $signed(i_bits << w_gap);
      w_sext    = w_aligned >>> w_gap;
      o_data    = w_sext << i_offset;
   end

endmodule

// File: rtl/precision_unpacker.sv
// Unpacks a dense LSB-first stream of prec-bit values from N-bit words and
// emits one sign-extended, offset-aligned N-bit value per output handshake.
module precision_unpacker
   import stripes_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned BIT_IDX = BIT_IDX_DEF,
   parameter int unsigned PREC_W  = PREC_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [PREC_W-1:0]  i_prec,
   input  logic [BIT_IDX-1:0] i_offset,
   input  logic [CNT_W-1:0]   i_num,
   output logic               o_cfg_err,
   output logic               o_busy,
   input  logic               i_in_valid,
   input  logic [N-1:0]       i_in_data,
   output logic               o_in_ready,
   output logic               o_out_valid,
   output logic [N-1:0]       o_out_data,
   input  logic               i_out_ready,
   output logic               o_done
);

   localparam int unsigned FILL_W = $clog2(2*N+1);
   localparam int unsigned PROD_W = CNT_W + PREC_W;

   state_t               r_state, w_state_nxt;
   logic [PREC_W-1:0]    r_prec;
   logic [BIT_IDX-1:0]   r_offset;
   logic [CNT_W-1:0]     r_vals_left, r_words_left;
   logic [2*N-1:0]       r_buf;
   logic [FILL_W-1:0]    r_fill;
   logic                 r_out_valid, r_cfg_err, r_done;
   logic [N-1:0]         r_out_data;

   logic                 w_cfg_bad, w_in_ready, w_in_fire, w_extract, w_out_fire, w_last;
   logic [PREC_W:0]      w_prec_sum;
   logic [PROD_W-1:0]    w_prod;
   logic [CNT_W-1:0]     w_words;
   logic [FILL_W-1:0]    w_prec_f, w_fill_after, w_fill_next;
   logic [2*N-1:0]       w_buf_shift, w_buf_next;
   logic [N-1:0]         w_expanded;

   precision_expand #(.N(N), .BIT_IDX(BIT_IDX), .PREC_W(PREC_W)) u_expand (
      .i_bits   (r_buf[N-1:0]),
      .i_prec   (r_prec),
      .i_offset (r_offset),
      .o_data   (w_expanded)
   );

   always_comb begin
      w_prec_sum = {1'b0, i_prec} + (PREC_W+1)'(i_offset);
      w_cfg_bad  = (i_prec == '0) || ({1'b0, i_prec} > (PREC_W+1)'(N)) ||
                   (w_prec_sum > (PREC_W+1)'(N)) || (i_num == '0);
      w_prod     = PROD_W'(i_num) * PROD_W'(i_prec);
      w_words    = CNT_W'(ceil_div(32'(w_prod), 32'(N)));
   end

   // Incoming word lands just above whatever survives this cycle's extraction.
   always_comb begin
      w_prec_f     = FILL_W'(r_prec);
      w_in_ready   = (r_state == ST_RUN) && (r_words_left != '0) && (r_fill <= FILL_W'(N));
      w_in_fire    = i_in_valid && w_in_ready;
      w_out_fire   = r_out_valid && i_out_ready;
      w_extract    = (r_state == ST_RUN) && (r_vals_left != '0) && (r_fill >= w_prec_f) &&
                     (!r_out_valid || i_out_ready);
      w_last       = w_extract && (r_vals_left == CNT_W'(1));
      w_buf_shift  = w_extract ? (r_buf >> r_prec) : r_buf;
      w_fill_after = w_extract ? (r_fill - w_prec_f) : r_fill;
      w_buf_next   = w_in_fire ? (w_buf_shift | ({{N{1'b0}}, i_in_data} << w_fill_after)) : w_buf_shift;
      w_fill_next  = w_fill_after + (w_in_fire ? FILL_W'(N) : '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (i_start && !w_cfg_bad) w_state_nxt = ST_RUN;
         ST_RUN:   if (w_last) w_state_nxt = ST_FLUSH;
         ST_FLUSH: if (w_out_fire) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prec       <= '0;
         r_offset     <= '0;
         r_vals_left  <= '0;
         r_words_left <= '0;
         r_buf        <= '0;
         r_fill       <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_cfg_err    <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_cfg_err <= (r_state == ST_IDLE) && i_start && w_cfg_bad;
         r_done    <= (r_state == ST_FLUSH) && w_out_fire;
         case (r_state)
            ST_IDLE: begin
               if (i_start && !w_cfg_bad) begin
                  r_prec       <= i_prec;
                  r_offset     <= i_offset;
                  r_vals_left  <= i_num;
                  r_words_left <= w_words;
                  r_buf        <= '0;
                  r_fill       <= '0;
               end
            end
            ST_RUN: begin
               // Padding left in the final word is dropped as the last value loads.
               if (w_last) begin
                  r_buf  <= '0;
                  r_fill <= '0;
               end else begin
                  r_buf  <= w_buf_next;
                  r_fill <= w_fill_next;
               end
               if (w_in_fire) r_words_left <= r_words_left - CNT_W'(1);
               if (w_extract) r_vals_left <= r_vals_left - CNT_W'(1);
            end
            ST_FLUSH: begin
               if (w_out_fire) begin
                  r_buf  <= '0;
                  r_fill <= '0;
               end
            end
            default: ;
         endcase
         if (w_extract) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_expanded;
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_cfg_err   = r_cfg_err;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_done      = r_done;

endmodule

// File: tb/tb_precision_unpacker.sv
// Self-checking bench for precision_unpacker: directed scenarios plus random
// packets checked against a bitstream-level reference model.
module tb_precision_unpacker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [4:0]  i_prec = '0;
   logic [3:0]  i_offset = '0;
   logic [15:0] i_num = '0;
   logic        o_cfg_err, o_busy;
   logic        i_in_valid = 1'b0;
   logic [15:0] i_in_data = '0;
   logic        o_in_ready, o_out_valid;
   logic [15:0] o_out_data;
   logic        i_out_ready = 1'b0;
   logic        o_done;

   int checks = 0;
   int errors = 0;
   logic [15:0] w_q[$];
   logic [15:0] e_q[$];

   precision_unpacker #(.N(16), .BIT_IDX(4), .PREC_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_prec(i_prec), .i_offset(i_offset),
      .i_num(i_num), .o_cfg_err(o_cfg_err), .o_busy(o_busy), .i_in_valid(i_in_valid),
      .i_in_data(i_in_data), .o_in_ready(o_in_ready), .o_out_valid(o_out_valid),
      .o_out_data(o_out_data), .i_out_ready(i_out_ready), .o_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int prec, input int offset, input int num);
      @(negedge clk);
      i_start  = 1'b1;
      i_prec   = 5'(prec);
      i_offset = 4'(offset);
      i_num    = 16'(num);
      @(negedge clk);
      i_start  = 1'b0;
   endtask

   task automatic cfg_reject(input string tag, input int prec, input int offset, input int num);
      do_start(prec, offset, num);
      #1;
      check({tag, "_err"}, o_cfg_err, 1);
      check({tag, "_busy"}, o_busy, 0);
      @(negedge clk);
      #1;
      check({tag, "_pulse"}, o_cfg_err, 0);
   endtask

   // Runs one packet from w_q; expectations come from e_q if given, else the model.
   task automatic run_packet(input string tag, input int prec, input int offset, input int num,
                             input int vprob, input int rprob, input int stall_after, input bit check_tp);
      logic [15:0] exp_q[$];
      exp_q = {};
      if (e_q.size() != 0) begin
         exp_q = e_q;
      end else begin
         for (int k = 0; k < num; k++) begin
            int v = 0;
            for (int b = 0; b < prec; b++) begin
               int pos = k * prec + b;
               logic [15:0] wd;
               wd = w_q[pos / 16];
               if (wd[pos % 16]) v += (1 << b);
            end
            if (v >= (1 << (prec - 1))) v -= (1 << prec);
            exp_q.push_back(16'(v * (1 << offset)));
         end
      end
      do_start(prec, offset, num);
      #1;
      check({tag, "_busy"}, o_busy, 1);
      fork
         begin : feeder
            int wi = 0;
            int cyc = 0;
            while (wi < w_q.size() && cyc < 4000) begin
               @(negedge clk);
               i_in_valid = ($urandom_range(99) < vprob);
               i_in_data  = i_in_valid ? w_q[wi] : 16'($urandom);
               #1;
               if (i_in_valid && o_in_ready) wi++;
               cyc++;
            end
            check({tag, "_feed_all"}, wi, w_q.size());
            @(negedge clk);
            i_in_valid = 1'b0;
            #1;
            check({tag, "_in_ready_after"}, o_in_ready, 0);
         end
         begin : collector
            int oi = 0;
            int cyc = 0;
            int first_c = 0;
            int last_c = 0;
            int stall_cnt = 0;
            bit stalled = 0;
            logic [15:0] held = '0;
            while (oi < num && cyc < 4000) begin
               @(negedge clk);
               if (stall_after >= 0 && oi == stall_after && stall_cnt < 5) begin
                  i_out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  i_out_ready = ($urandom_range(99) < rprob);
               end
               #1;
               if (stalled) begin
                  check({tag, "_hold_valid"}, o_out_valid, 1);
                  check({tag, "_hold_data"}, o_out_data, held);
               end
               if (stall_after >= 0 && oi == stall_after && stall_cnt == 5 && !i_out_ready)
                  check({tag, "_stall_in_ready"}, o_in_ready, 0);
               if (o_out_valid && i_out_ready) begin
                  check({tag, "_data"}, o_out_data, exp_q[oi]);
                  check({tag, "_done_early"}, o_done, 0);
                  if (oi == 0) first_c = cyc;
                  last_c = cyc;
                  oi++;
                  stalled = 0;
                  if (oi == num) begin
                     @(posedge clk);
                     #1;
                     check({tag, "_done"}, o_done, 1);
                     check({tag, "_idle"}, o_busy, 0);
                     @(posedge clk);
                     #1;
                     check({tag, "_done_pulse"}, o_done, 0);
                  end
               end else begin
                  stalled = o_out_valid;
                  held    = o_out_data;
               end
               cyc++;
            end
            check({tag, "_out_all"}, oi, num);
            if (check_tp) check({tag, "_throughput"}, last_c - first_c, num - 1);
            i_out_ready = 1'b0;
         end
      join
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_in_ready", o_in_ready, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_done", o_done, 0);
      check("rst_cfg_err", o_cfg_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full precision pass-through
      w_q = {}; e_q = {};
      w_q.push_back(16'h8001); w_q.push_back(16'h7FFF); w_q.push_back(16'h0000);
      e_q.push_back(16'h8001); e_q.push_back(16'h7FFF); e_q.push_back(16'h0000);
      run_packet("full", 16, 0, 3, 100, 100, -1, 1'b1);

      // Sub-word values with offset
      w_q = {}; e_q = {};
      w_q.push_back(16'hF831);
      e_q.push_back(16'h0004); e_q.push_back(16'h000C); e_q.push_back(16'hFFE0); e_q.push_back(16'hFFFC);
      run_packet("sub", 4, 2, 4, 100, 100, -1, 1'b1);

      // Value spanning two words
      w_q = {}; e_q = {};
      w_q.push_back(16'h8421); w_q.push_back(16'h000F);
      e_q.push_back(16'h0001); e_q.push_back(16'h0001); e_q.push_back(16'h0001); e_q.push_back(16'hFFFF);
      run_packet("span", 5, 0, 4, 100, 100, -1, 1'b0);

      // Backpressure mid-stream
      w_q = {}; e_q = {};
      for (int i = 0; i < 4; i++) w_q.push_back(16'($urandom));
      run_packet("bp", 4, 0, 16, 100, 100, 6, 1'b0);

      // Configuration rejects
      cfg_reject("cfg_sum", 12, 6, 3);
      cfg_reject("cfg_p0", 0, 0, 3);
      cfg_reject("cfg_n0", 8, 0, 0);
      cfg_reject("cfg_p17", 17, 0, 3);

      // prec + offset exactly N is legal
      w_q = {}; e_q = {};
      for (int i = 0; i < 3; i++) w_q.push_back(16'($urandom));
      run_packet("edge_sum", 8, 8, 6, 80, 80, -1, 1'b0);

      // Start during RUN is ignored, then asynchronous reset mid-operation
      do_start(8, 0, 4);
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_data  = 16'($urandom);
      i_out_ready = 1'b0;
      for (int i = 0; i < 10 && !o_out_valid; i++) @(negedge clk);
      #1;
      check("mid_valid_seen", o_out_valid, 1);
      i_start = 1'b1;
      i_prec  = 5'd0;
      @(negedge clk);
      i_start = 1'b0;
      #1;
      check("run_start_no_err", o_cfg_err, 0);
      check("run_start_busy", o_busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", o_out_valid, 0);
      check("arst_out_data", o_out_data, 0);
      check("arst_busy", o_busy, 0);
      check("arst_in_ready", o_in_ready, 0);
      check("arst_done", o_done, 0);
      check("arst_cfg_err", o_cfg_err, 0);
      @(negedge clk);
      i_in_valid = 1'b0;
      rst_n = 1'b1;
      w_q = {}; e_q = {};
      w_q.push_back(16'h80FF);
      e_q.push_back(16'hFFFF); e_q.push_back(16'hFF80);
      run_packet("post_rst", 8, 0, 2, 100, 100, -1, 1'b1);

      // Random packets against the reference model
      for (int t = 0; t < 25; t++) begin
         int prec = $urandom_range(16, 1);
         int offset = $urandom_range(16 - prec, 0);
         int num = $urandom_range(12, 1);
         int nw = (num * prec + 15) / 16;
         w_q = {}; e_q = {};
         for (int i = 0; i < nw; i++) w_q.push_back(16'($urandom));
         run_packet("rand", prec, offset, num, $urandom_range(100, 40), $urandom_range(100, 30), -1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
